// File: rtl/crp16_mem_arbiter_pkg.sv
// Shared definitions for the CRP16 memory arbiter.
// Holds the width defaults used by the arbiter parameters and the requester
// index encoding (DP = 0, DBG = 1) shared by the top and the round-robin core.
package crp16_mem_arbiter_pkg;

  localparam int unsigned AddrWDef = 16;
  localparam int unsigned DataWDef = 16;
  localparam int unsigned CntWDef  = 16;

  // Requester index; also the bit position of each requester in req/gnt vectors.
  typedef enum logic {
    ReqDp  = 1'b0,
    ReqDbg = 1'b1
  } req_idx_e;

endpackage

// File: rtl/crp16_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with debug-owner lock.
// Ports:
//   req  in  [1:0]  requests, bit 0 = datapath, bit 1 = debug loader
//   lock in         debug lock; while debug won last, only debug may be granted
//   last in         requester granted most recently
//   gnt  out [1:0]  one-hot (or zero) grant, purely combinational
module crp16_rr_arb2
  import crp16_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lock,
  input  req_idx_e   last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (last == ReqDbg && lock) begin
      // Debug owns the port: no alternation, datapath waits.
      gnt[1] = req[1];
    end else if (req == 2'b11) begin
      // Tie goes to whoever was not granted most recently.
      gnt = (last == ReqDbg) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/crp16_mem_arbiter.sv
// CRP16 memory arbiter: shares one single-port RAM between the datapath and
// the debug loader.
// Ports:
//   clock, reset                    clock; asynchronous active-high reset
//   dp_*/dbg_* req, we, addr, wdata request side of each requester
//   dbg_lock                        debug keeps the port while it owns it
//   dp_gnt/dbg_gnt                  access accepted this cycle (combinational)
//   dp_rvalid/dbg_rvalid, *_rdata   read return, one cycle after the grant
//   mem_address/mem_data/mem_wren   RAM port; mem_q is RAM read data (1-cycle)
//   dp_grants/dbg_grants            saturating grant counters
module crp16_mem_arbiter
  import crp16_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned CNT_W  = CntWDef
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dp_req,
  input  logic              dp_we,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_wdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dp_gnt,
  output logic              dbg_gnt,
  output logic              dp_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dp_rdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [CNT_W-1:0]  dp_grants,
  output logic [CNT_W-1:0]  dbg_grants
);

  logic [1:0]        req;
  logic [1:0]        gnt_raw;
  logic [1:0]        gnt;
  logic [1:0]        rd_pend_q;
  req_idx_e          last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dp_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  assign req = {dbg_req, dp_req};

  crp16_rr_arb2 u_arb (
    .req  (req),
    .lock (dbg_lock),
    .last (last_q),
    .gnt  (gnt_raw)
  );

  // Grants are forced low while reset is asserted, independent of the clock.
  assign gnt     = reset ? 2'b00 : gnt_raw;
  assign dp_gnt  = gnt[0];
  assign dbg_gnt = gnt[1];

  // RAM port follows the winner in the grant cycle, otherwise holds its last value.
  always_comb begin
    mem_address = addr_q;
    mem_data    = data_q;
    mem_wren    = 1'b0;
    if (gnt[1]) begin
      mem_address = dbg_addr;
      mem_data    = dbg_wdata;
      mem_wren    = dbg_we;
    end else if (gnt[0]) begin
      mem_address = dp_addr;
      mem_data    = dp_wdata;
      mem_wren    = dp_we;
    end
  end

  assign dp_rvalid  = rd_pend_q[0];
  assign dbg_rvalid = rd_pend_q[1];
  assign dp_rdata   = rd_pend_q[0] ? mem_q : dp_rdata_q;
  assign dbg_rdata  = rd_pend_q[1] ? mem_q : dbg_rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q      <= ReqDbg;
      addr_q      <= '0;
      data_q      <= '0;
      rd_pend_q   <= 2'b00;
      dp_rdata_q  <= '0;
      dbg_rdata_q <= '0;
      dp_grants   <= '0;
      dbg_grants  <= '0;
    end else begin
      rd_pend_q <= gnt & ~{dbg_we, dp_we};
      if (|gnt) begin
        last_q <= gnt[1] ? ReqDbg : ReqDp;
        addr_q <= mem_address;
        data_q <= mem_data;
      end
      // Capture returned data so rdata holds once rvalid drops.
      if (rd_pend_q[0]) dp_rdata_q <= mem_q;
      if (rd_pend_q[1]) dbg_rdata_q <= mem_q;
      if (gnt[0] && dp_grants != '1) dp_grants <= dp_grants + CNT_W'(1);
      if (gnt[1] && dbg_grants != '1) dbg_grants <= dbg_grants + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_crp16_mem_arbiter.sv
// Self-checking bench for crp16_mem_arbiter: directed vectors, expected read
// returns queued at grant time and checked by a monitor when rvalid appears.
`timescale 1ns / 1ps
module tb_crp16_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        dp_req, dp_we, dbg_req, dbg_we, dbg_lock;
  logic [15:0] dp_addr, dp_wdata, dbg_addr, dbg_wdata;
  logic        dp_gnt, dbg_gnt, dp_rvalid, dbg_rvalid, mem_wren;
  logic [15:0] dp_rdata, dbg_rdata, mem_address, mem_data, mem_q;
  logic [15:0] dp_grants, dbg_grants;

  crp16_mem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .dp_req      (dp_req),
    .dp_we       (dp_we),
    .dp_addr     (dp_addr),
    .dp_wdata    (dp_wdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_lock    (dbg_lock),
    .dp_gnt      (dp_gnt),
    .dbg_gnt     (dbg_gnt),
    .dp_rvalid   (dp_rvalid),
    .dbg_rvalid  (dbg_rvalid),
    .dp_rdata    (dp_rdata),
    .dbg_rdata   (dbg_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .dp_grants   (dp_grants),
    .dbg_grants  (dbg_grants)
  );

  typedef struct {
    logic        port;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ram[0:65535];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drv(input logic pr, input logic pw, input logic [15:0] pa, input logic [15:0] pd,
                     input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
                     input logic lk);
    dp_req = pr; dp_we = pw; dp_addr = pa; dp_wdata = pd;
    dbg_req = br; dbg_we = bw; dbg_addr = ba; dbg_wdata = bd;
    dbg_lock = lk;
  endtask

  task automatic idle();
    drv(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected read return for a grant in the current cycle.
  task automatic push(input logic port, input logic [15:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    mem_q <= 16'h0;
    ram[16'h0010] <= 16'hBEEF;
    ram[16'h0020] <= 16'h1111;
    ram[16'h0021] <= 16'h2222;

    fork
      // Behavioural RAM: one-cycle read latency.
      forever begin
        @(posedge clock);
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
      end
      // Scoreboard monitor.
      forever begin
        @(negedge clock);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          checks++;
          $display("FAIL rvalid_missing: got none, expected port %0d data %h at cycle %0d",
                   sb[0].port, sb[0].data, sb[0].due);
          void'(sb.pop_front());
        end
        if (dp_rvalid || dbg_rvalid) begin
          checks++;
          if (sb.size() == 0) begin
            $display("FAIL rvalid_unexpected: got dp_rvalid=%b dbg_rvalid=%b, expected none",
                     dp_rvalid, dbg_rvalid);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (dp_rvalid && dbg_rvalid || e.port !== dbg_rvalid || e.due != cyc ||
                e.data !== (dbg_rvalid ? dbg_rdata : dp_rdata))
              $display("FAIL rdata: got port %0d data %h cycle %0d, expected port %0d data %h cycle %0d",
                       dbg_rvalid, dbg_rvalid ? dbg_rdata : dp_rdata, cyc, e.port, e.data, e.due);
            else passed++;
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    chk("reset_dp_gnt", dp_gnt, 0);
    chk("reset_dbg_gnt", dbg_gnt, 0);
    chk("reset_rvalid", {dp_rvalid, dbg_rvalid}, 0);
    chk("reset_mem", {mem_address, mem_data, 15'h0, mem_wren}, 0);
    chk("reset_counters", {dp_grants, dbg_grants}, 0);
    reset = 1'b0;
    tick();

    // Continuous tie: strict alternation starting with the datapath.
    drv(1, 0, 16'h0020, 16'h0, 1, 0, 16'h0021, 16'h0, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_gnt_%0d", i), {dp_gnt, dbg_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      push((i % 2 == 0) ? 1'b0 : 1'b1, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      tick();
    end
    idle();
    chk("rr_dp_grants", dp_grants, 3);
    chk("rr_dbg_grants", dbg_grants, 3);

    // Lone datapath read.
    tick();
    drv(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    #1;
    chk("dp_read_gnt", {dp_gnt, dbg_gnt}, 2'b10);
    chk("dp_read_addr", {mem_address, 15'h0, mem_wren}, {16'h0010, 16'h0});
    push(0, 16'hBEEF);
    tick();
    idle();
    tick();
    tick();
    chk("dp_rdata_hold", {dp_rvalid, dp_rdata}, {1'b0, 16'hBEEF});

    // Debug write then datapath read of the same address.
    drv(0, 0, 16'h0, 16'h0, 1, 1, 16'h0005, 16'h1234, 0);
    #1;
    chk("dbg_write_gnt", {dp_gnt, dbg_gnt}, 2'b01);
    chk("dbg_write_port", {mem_address, mem_data, 15'h0, mem_wren}, {16'h0005, 16'h1234, 16'h1});
    tick();
    drv(1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    #1;
    chk("dp_after_write_gnt", {dp_gnt, dbg_gnt}, 2'b10);
    push(0, 16'h1234);
    tick();
    idle();
    #1;
    chk("idle_port_hold", {mem_address, 15'h0, mem_wren}, {16'h0005, 16'h0});
    tick();

    // Debug lock: debug keeps the port while both request.
    drv(0, 0, 16'h0, 16'h0, 1, 1, 16'h0030, 16'hAAAA, 1);
    #1;
    chk("lock_first_gnt", {dp_gnt, dbg_gnt}, 2'b01);
    tick();
    drv(1, 0, 16'h0010, 16'h0, 1, 1, 16'h0030, 16'hAAAA, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("lock_gnt_%0d", i), {dp_gnt, dbg_gnt}, 2'b01);
      tick();
    end
    drv(1, 0, 16'h0010, 16'h0, 1, 1, 16'h0030, 16'hAAAA, 0);
    #1;
    chk("unlock_gnt", {dp_gnt, dbg_gnt}, 2'b10);
    push(0, 16'hBEEF);
    tick();
    idle();
    tick();

    // Reset in the middle of a granted read.
    drv(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    #1;
    chk("pre_reset_gnt", dp_gnt, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_gnt", {dp_gnt, dbg_gnt, dp_rvalid, dbg_rvalid}, 0);
    chk("async_reset_rdata", {dp_rdata, dbg_rdata}, 0);
    chk("async_reset_mem", {mem_address, mem_data, 15'h0, mem_wren}, 0);
    chk("async_reset_counters", {dp_grants, dbg_grants}, 0);
    tick();
    idle();
    tick();
    reset = 1'b0;
    tick();
    tick();
    drv(1, 0, 16'h0020, 16'h0, 1, 0, 16'h0021, 16'h0, 0);
    #1;
    chk("post_reset_tie", {dp_gnt, dbg_gnt}, 2'b10);
    push(0, 16'h1111);
    tick();

    // Grant-counter saturation (one datapath grant already counted).
    drv(1, 1, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    repeat (65533) tick();
    chk("sat_fffe", dp_grants, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_ffff_%0d", i), dp_grants, 16'hFFFF);
    end
    idle();
    tick();
    tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
